// File: rtl/pipe_ctrl.sv
// Hazard and exception controller for the five-stage MIPS pipeline: stall/bubble
// controls, HI/LO busy window sequencing and a free-running stall-cycle counter.
module pipe_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic [4:0]  E_GRF_A3,
    input  logic [4:0]  M_GRF_A3,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        D_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    input  logic        D_eret,
    input  logic        E_mtc0_epc,
    input  logic        M_mtc0_epc,
    input  logic        int_req,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr,
    output logic        req,
    output logic        md_busy,
    output logic        stall,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    logic [3:0] md_cnt;
    logic       hz_rs;
    logic       hz_rt;
    logic       hz_md;
    logic       hz_eret;

    // A tuse of 3 can never be below a 2-bit tnew, so unused operands never stall.
    always_comb begin
        hz_rs = (D_rs != 5'd0) &&
                (((D_rs == E_GRF_A3) && (D_rs_tuse < E_tnew)) ||
                 ((D_rs == M_GRF_A3) && (D_rs_tuse < M_tnew)));
        hz_rt = (D_rt != 5'd0) &&
                (((D_rt == E_GRF_A3) && (D_rt_tuse < E_tnew)) ||
                 ((D_rt == M_GRF_A3) && (D_rt_tuse < M_tnew)));
        hz_md   = D_md && (md_busy || E_md_start);
        hz_eret = D_eret && (E_mtc0_epc || M_mtc0_epc);
        stall   = hz_rs || hz_rt || hz_md || hz_eret;
    end

    // The exception request overrides the stall so the flush can proceed.
    always_comb begin
        req = int_req;
        if (req) begin
            F_en  = 1'b1;
            D_en  = 1'b1;
            E_clr = 1'b0;
        end else if (stall) begin
            F_en  = 1'b0;
            D_en  = 1'b0;
            E_clr = 1'b1;
        end else begin
            F_en  = 1'b1;
            D_en  = 1'b1;
            E_clr = 1'b0;
        end
    end

    // A start being flushed by req is dropped; a running count is not cancelled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (E_md_start && !req) begin
            md_cnt <= E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    assign md_busy = (md_cnt != 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall && !req) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/busy/reset scenarios followed
// by randomized stimulus against a cycle-indexed reference model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_GRF_A3, M_GRF_A3;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_md, E_md_start, E_md_div, D_eret, E_mtc0_epc, M_mtc0_epc, int_req;
    logic        F_en, D_en, E_clr, req, md_busy, stall;
    logic [31:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    // Reference model: the busy window is tracked as an absolute edge number.
    int unsigned edge_num = 0;
    int unsigned busy_end = 0;
    logic [31:0] exp_cnt  = 32'd0;

    pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .E_GRF_A3(E_GRF_A3), .M_GRF_A3(M_GRF_A3), .E_tnew(E_tnew), .M_tnew(M_tnew),
        .D_md(D_md), .E_md_start(E_md_start), .E_md_div(E_md_div), .D_eret(D_eret),
        .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc), .int_req(int_req),
        .F_en(F_en), .D_en(D_en), .E_clr(E_clr), .req(req), .md_busy(md_busy),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic m_busy();
        return edge_num < busy_end;
    endfunction

    function automatic logic reg_hz(input logic [4:0] r, input logic [1:0] tuse);
        int t = int'(tuse);
        if (r == 5'd0) return 1'b0;
        if (r == E_GRF_A3 && t < int'(E_tnew)) return 1'b1;
        if (r == M_GRF_A3 && t < int'(M_tnew)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_stall();
        return reg_hz(D_rs, D_rs_tuse) || reg_hz(D_rt, D_rt_tuse) ||
               (D_md && (m_busy() || E_md_start)) ||
               (D_eret && (E_mtc0_epc || M_mtc0_epc));
    endfunction

    task automatic model_reset();
        busy_end = edge_num;
        exp_cnt  = 32'd0;
    endtask

    task automatic check_all();
        logic s;
        #1;
        s = m_stall();
        check("stall", {31'd0, stall}, {31'd0, s});
        check("req", {31'd0, req}, {31'd0, int_req});
        check("F_en", {31'd0, F_en}, {31'd0, int_req || !s});
        check("D_en", {31'd0, D_en}, {31'd0, int_req || !s});
        check("E_clr", {31'd0, E_clr}, {31'd0, !int_req && s});
        check("md_busy", {31'd0, md_busy}, {31'd0, m_busy()});
        check("stall_cnt", stall_cnt, exp_cnt);
    endtask

    task automatic tick();
        logic s;
        check_all();
        s = m_stall();
        @(posedge clk);
        if (!reset) begin
            edge_num++;
            if (s && !int_req) exp_cnt = exp_cnt + 32'd1;
            if (E_md_start && !int_req) busy_end = edge_num + (E_md_div ? 10 : 5);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        E_GRF_A3 = 5'd0; M_GRF_A3 = 5'd0; E_tnew = 2'd0; M_tnew = 2'd0;
        D_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0; D_eret = 1'b0;
        E_mtc0_epc = 1'b0; M_mtc0_epc = 1'b0; int_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n_stall;
        int n_busy;
        idle();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        tick();
        reset = 1'b0;

        // Load-use then forwardable result
        idle();
        E_GRF_A3 = 5'd5; E_tnew = 2'd2; D_rs = 5'd5; D_rs_tuse = 2'd1;
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_F_en", {31'd0, F_en}, 32'd0);
        check("lu_D_en", {31'd0, D_en}, 32'd0);
        check("lu_E_clr", {31'd0, E_clr}, 32'd1);
        tick();
        E_tnew = 2'd1;
        #1;
        check("lu_fwd_stall", {31'd0, stall}, 32'd0);
        tick();

        // $0 and unused operand
        idle();
        D_rs = 5'd0; E_GRF_A3 = 5'd0; E_tnew = 2'd2; D_rs_tuse = 2'd0;
        #1;
        check("zero_reg_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        D_rt = 5'd7; E_GRF_A3 = 5'd7; E_tnew = 2'd3; D_rt_tuse = 2'd3;
        #1;
        check("unused_rt_stall", {31'd0, stall}, 32'd0);
        D_rt_tuse = 2'd0;
        #1;
        check("used_rt_stall", {31'd0, stall}, 32'd1);
        tick();

        // Multiply busy window
        idle();
        do_reset();
        D_md = 1'b1; E_md_start = 1'b1; E_md_div = 1'b0;
        n_stall = 0; n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_stall += int'(stall);
            n_busy  += int'(md_busy);
            tick();
            E_md_start = 1'b0;
        end
        check("mult_busy_cycles", n_busy, 5);
        check("mult_stall_cycles", n_stall, 6);
        D_md = 1'b0;
        #1;
        check("mult_stall_cnt", stall_cnt, 32'd6);
        tick();

        // Divide flushed by exception
        idle();
        E_md_start = 1'b1; E_md_div = 1'b1; int_req = 1'b1;
        #1;
        check("flush_req", {31'd0, req}, 32'd1);
        check("flush_F_en", {31'd0, F_en}, 32'd1);
        check("flush_E_clr", {31'd0, E_clr}, 32'd0);
        tick();
        idle();
        #1;
        check("flush_md_busy", {31'd0, md_busy}, 32'd0);
        tick();

        // Exception during a running divide
        E_md_start = 1'b1; E_md_div = 1'b1;
        tick();
        idle();
        int_req = 1'b1;
        #1;
        check("int_div_busy", {31'd0, md_busy}, 32'd1);
        tick();
        int_req = 1'b0;
        n_busy = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_busy += int'(md_busy);
            tick();
        end
        check("int_div_remaining", n_busy, 9);

        // Eret after EPC write
        idle();
        D_eret = 1'b1; M_mtc0_epc = 1'b1;
        #1;
        check("eret_stall", {31'd0, stall}, 32'd1);
        tick();
        M_mtc0_epc = 1'b0;
        #1;
        check("eret_clear", {31'd0, stall}, 32'd0);
        tick();

        // Async reset mid-divide at md_cnt=7
        idle();
        E_md_start = 1'b1; E_md_div = 1'b1;
        tick();
        E_md_start = 1'b0; D_md = 1'b1;
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_md_busy", {31'd0, md_busy}, 32'd0);
        check("arst_stall_cnt", stall_cnt, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        tick();

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            D_rs = 5'($urandom_range(0, 3));
            D_rt = 5'($urandom_range(0, 3));
            D_rs_tuse = 2'($urandom_range(0, 3));
            D_rt_tuse = 2'($urandom_range(0, 3));
            E_GRF_A3 = 5'($urandom_range(0, 3));
            M_GRF_A3 = 5'($urandom_range(0, 3));
            E_tnew = 2'($urandom_range(0, 3));
            M_tnew = 2'($urandom_range(0, 3));
            D_md = ($urandom_range(0, 3) == 0);
            E_md_start = ($urandom_range(0, 5) == 0);
            E_md_div = 1'($urandom_range(0, 1));
            D_eret = ($urandom_range(0, 4) == 0);
            E_mtc0_epc = ($urandom_range(0, 3) == 0);
            M_mtc0_epc = ($urandom_range(0, 3) == 0);
            int_req = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            if (reset) model_reset();
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
